packet_buffer_read_scheduler: RTL and testbench
===============================================

# packet_buffer_read_scheduler

Read-side controller for a set of per-port packet buffers (length FIFO plus packet SRAM). Arbitrates round-robin among non-empty buffers, pops the packet length, drives the granted buffer's read enable for exactly that many cycles, and muxes the returned bytes into a single framed stream with start, end and port tags. Sits between the packet buffers and the downstream transmit/switch logic.

## Interface
- pPORTS, 4, number of packet buffers served (2..8)
- pDATA_WIDTH, 8, byte bus width
- pLEN_WIDTH, 16, length field width
- pMAX_PACKET_LENGHT, 1536, largest legal packet length in bytes
- pRD_LATENCY, 1, buffer SRAM read latency in cycles (ord_en to ird_data valid)

- iclk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- iempty  in  pPORTS  per-buffer empty; bit i high = no complete packet
- ilen  in  pPORTS*pLEN_WIDTH  head-of-FIFO packet length per buffer, valid when iempty[i]=0
- ird_data  in  pPORTS*pDATA_WIDTH  per-buffer SRAM read data
- idst_ready  in  1  downstream can take a new packet; sampled only in IDLE
- ord_en  out  pPORTS  one-hot buffer read enable
- olen_pop  out  pPORTS  one-hot, one-cycle length FIFO pop
- odata  out  pDATA_WIDTH  output byte
- odv  out  1  odata valid
- osop, oeop  out  1 each  first/last byte of packet, qualified by odv
- oport  out  $clog2(pPORTS)  source port of current packet
- olen  out  pLEN_WIDTH  length of current packet, stable from osop through oeop
- oerr  out  1  one-cycle pulse: illegal length popped and discarded

## Operation
- States: IDLE, POP, READ, DRAIN, GAP.
- IDLE: if idst_ready=1 and any iempty[i]=0, grant = first non-empty port strictly after last_grant (wrapping); latch grant and ilen[grant]; go POP. Otherwise stay.
- POP: olen_pop[grant]=1 for this cycle only; last_grant <= grant. If latched length is 0 or > pMAX_PACKET_LENGHT: oerr=1, go GAP. Else rd_cnt <= length, go READ.
- READ: ord_en[grant]=1 every cycle; rd_cnt decrements; on cycle with rd_cnt=1 go DRAIN.
- DRAIN: wait until output pipeline empty (L-1 cycles, L = pRD_LATENCY+1), then GAP.
- GAP: one idle cycle, then IDLE.
- Output pipeline: ord_en shifted through L stages with sop/eop tags; odata registered from ird_data[grant]. osop tags first ord_en cycle, oeop tags the rd_cnt=1 cycle; length 1 gives osop=oeop=1 on the same byte.
- iempty/ilen of non-granted ports ignored after IDLE; changes to idst_ready mid-packet have no effect (no mid-packet backpressure).
- rd_cnt is pLEN_WIDTH wide; never underflows (legal lengths are ≥1).
- Reset: all outputs 0, state IDLE, pipeline flushed, last_grant = pPORTS-1 (port 0 highest priority first). Reset mid-READ truncates the packet silently; no oeop is emitted.

## Timing
- Request seen in IDLE at cycle 0 → olen_pop at cycle 1 → first ord_en at cycle 2 → first odv/osop at cycle 2+L.
- Packet of N bytes: ord_en cycles 2..N+1; odv cycles 2+L..N+1+L, contiguous, no gaps.
- Next IDLE evaluation at cycle N+2+L; minimum inter-packet spacing on odv is 3 idle cycles (POP, GAP, IDLE) plus the IDLE decision cycle.
- Illegal length: oerr at cycle 1, IDLE again at cycle 3; no ord_en, no odv.

## Structure
- Shared package copy_mem_pkg: state enum (IDLE, POP, READ, DRAIN, GAP), default pLEN_WIDTH, pMAX_PACKET_LENGHT, helper for one-hot from index.
- Sub-module rr_arbiter (pPORTS request vector, last-grant pointer in, grant index + valid out, purely combinational); scheduler holds the pointer register.

## Test plan
- Port 2 only, len 64, pRD_LATENCY=1 → olen_pop[2] once, 64 cycles ord_en[2], odv for 64 contiguous cycles starting 3 cycles after olen_pop, osop first, oeop last, oport=2, olen=64.
- Ports 0,1,3 all non-empty, each len 10, repeated → grant order 0,1,3,0,1,3; no port served twice while another waits.
- Len 1 on port 1 → single odv with osop=oeop=1.
- Len 0 and len 1537 at head of port 0 → oerr pulse each, olen_pop each, zero ord_en/odv; next packet len 60 streams normally.
- idst_ready=0 with port 0 non-empty for 20 cycles → no olen_pop; raise idst_ready → olen_pop next cycle; drop it mid-packet → packet completes fully.
- i_rst asserted at 30th byte of a len-100 packet → next cycle all outputs 0; after release with port 3 and port 0 pending, port 0 granted first.

Source files
------------

// File: rtl/copy_mem_pkg.sv
// copy_mem_pkg
// Shared types and constants for the packet buffer read scheduler.
//   state_e                 scheduler FSM states
//   DEF_LEN_WIDTH           default width of a packet length field
//   DEF_MAX_PACKET_LENGTH   default largest legal packet length in bytes
//   MAX_PORTS               upper bound on the number of buffers served
//   onehot()                index -> one-hot vector (MAX_PORTS wide)
package copy_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int DEF_LEN_WIDTH         = 16;
    localparam int DEF_MAX_PACKET_LENGTH = 1536;
    localparam int MAX_PORTS             = 8;

    function automatic logic [MAX_PORTS-1:0] onehot(input logic [2:0] idx);
        logic [MAX_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: returns the first requesting index
// strictly after the last-granted index, wrapping around.
//   ireq    in   pPORTS  request vector
//   ilast   in   pIDX_W  index granted last time
//   ogrant  out  pIDX_W  chosen index (0 when ovalid=0)
//   ovalid  out  1       at least one request present
module rr_arbiter
    import copy_mem_pkg::*;
#(
    parameter int pPORTS = 4,
    parameter int pIDX_W = $clog2(pPORTS)
) (
    input  logic [pPORTS-1:0] ireq,
    input  logic [pIDX_W-1:0] ilast,
    output logic [pIDX_W-1:0] ogrant,
    output logic              ovalid
);

    logic [pIDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester after ilast is the last assignment and therefore wins.
    always_comb begin
        ogrant = '0;
        ovalid = 1'b0;
        cand   = '0;
        for (int k = pPORTS; k >= 1; k--) begin
            cand = pIDX_W'((int'(ilast) + k) % pPORTS);
            if (ireq[cand]) begin
                ogrant = cand;
                ovalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_buffer_read_scheduler.sv
// packet_buffer_read_scheduler
// Read-side controller for pPORTS packet buffers (length FIFO + packet SRAM).
// Picks a non-empty buffer round-robin, pops its length, reads that many bytes
// and reframes them onto one tagged output stream.
//   iclk, i_rst       clock, synchronous active-high reset
//   iempty, ilen      per-buffer empty flag and head-of-FIFO length
//   ird_data          per-buffer SRAM read data (pRD_LATENCY after ord_en)
//   idst_ready        downstream can accept a new packet
//   ord_en, olen_pop  one-hot buffer read enable / length pop
//   odata, odv        output byte and its valid
//   osop, oeop        first / last byte of packet (qualified by odv)
//   oport, olen       source port and length of current packet
//   oerr              pulse: illegal length popped and dropped
//   odbg_state        current FSM state
//
// Downstream handshake: idst_ready is a packet-level ready, sampled only in
// IDLE. Once a packet is granted it streams to completion on contiguous odv
// cycles; there is no per-byte backpressure.
module packet_buffer_read_scheduler
    import copy_mem_pkg::*;
#(
    parameter int pPORTS             = 4,
    parameter int pDATA_WIDTH        = 8,
    parameter int pLEN_WIDTH         = DEF_LEN_WIDTH,
    parameter int pMAX_PACKET_LENGHT = DEF_MAX_PACKET_LENGTH,
    parameter int pRD_LATENCY        = 1
) (
    input  logic                          iclk,
    input  logic                          i_rst,
    input  logic [pPORTS-1:0]             iempty,
    input  logic [pPORTS*pLEN_WIDTH-1:0]  ilen,
    input  logic [pPORTS*pDATA_WIDTH-1:0] ird_data,
    input  logic                          idst_ready,
    output logic [pPORTS-1:0]             ord_en,
    output logic [pPORTS-1:0]             olen_pop,
    output logic [pDATA_WIDTH-1:0]        odata,
    output logic                          odv,
    output logic                          osop,
    output logic                          oeop,
    output logic [$clog2(pPORTS)-1:0]     oport,
    output logic [pLEN_WIDTH-1:0]         olen,
    output logic                          oerr,
    output state_e                        odbg_state
);

    localparam int IDX_W = $clog2(pPORTS);
    // Stages from read enable to registered output byte (>= 2).
    localparam int L = pRD_LATENCY + 1;

    state_e                  state_q;
    logic [IDX_W-1:0]        last_q;
    logic [IDX_W-1:0]        grant_q;
    logic [pPORTS-1:0]       grant_oh_q;
    logic                    len_bad_q;
    logic [pLEN_WIDTH-1:0]   rd_cnt_q;
    logic                    first_q;
    logic [pPORTS-1:0]       ord_en_q;
    logic [pPORTS-1:0]       olen_pop_q;
    logic                    oerr_q;
    logic [IDX_W-1:0]        oport_q;
    logic [pLEN_WIDTH-1:0]   olen_q;
    logic [L-1:0]            vld_q;
    logic [L-1:0]            sop_q;
    logic [L-1:0]            eop_q;
    logic [pDATA_WIDTH-1:0]  odata_q;

    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_vld;
    logic [pPORTS-1:0]       req;
    logic [pLEN_WIDTH-1:0]   head_len;
    logic [pDATA_WIDTH-1:0]  rd_byte;
    logic                    len_bad;
    logic                    tag_vld;
    logic                    tag_sop;
    logic                    tag_eop;

    assign req = ~iempty;

    rr_arbiter #(
        .pPORTS (pPORTS),
        .pIDX_W (IDX_W)
    ) u_arb (
        .ireq   (req),
        .ilast  (last_q),
        .ogrant (arb_idx),
        .ovalid (arb_vld)
    );

    // Head length of the candidate port, and read data of the granted port.
    always_comb begin
        head_len = '0;
        rd_byte  = '0;
        for (int i = 0; i < pPORTS; i++) begin
            if (arb_idx == IDX_W'(i)) head_len = ilen[i*pLEN_WIDTH +: pLEN_WIDTH];
            if (grant_q == IDX_W'(i)) rd_byte = ird_data[i*pDATA_WIDTH +: pDATA_WIDTH];
        end
    end

    assign len_bad = (head_len == '0) ||
                     (head_len > pLEN_WIDTH'(pMAX_PACKET_LENGHT));

    // Tags for the byte whose read enable is being issued this cycle.
    assign tag_vld = (state_q == ST_READ);
    assign tag_sop = tag_vld && first_q;
    assign tag_eop = tag_vld && (rd_cnt_q == pLEN_WIDTH'(1));

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(pPORTS - 1);
            grant_q    <= '0;
            grant_oh_q <= '0;
            len_bad_q  <= 1'b0;
            rd_cnt_q   <= '0;
            first_q    <= 1'b0;
            ord_en_q   <= '0;
            olen_pop_q <= '0;
            oerr_q     <= 1'b0;
            oport_q    <= '0;
            olen_q     <= '0;
            vld_q      <= '0;
            sop_q      <= '0;
            eop_q      <= '0;
            odata_q    <= '0;
        end else begin
            olen_pop_q <= '0;
            oerr_q     <= 1'b0;

            vld_q   <= {vld_q[L-2:0], tag_vld};
            sop_q   <= {sop_q[L-2:0], tag_sop};
            eop_q   <= {eop_q[L-2:0], tag_eop};
            // Stage L-2 lines up with SRAM data for that read enable.
            odata_q <= vld_q[L-2] ? rd_byte : '0;

            case (state_q)
                ST_IDLE: begin
                    if (idst_ready && arb_vld) begin
                        grant_q    <= arb_idx;
                        grant_oh_q <= pPORTS'(onehot(3'(arb_idx)));
                        olen_pop_q <= pPORTS'(onehot(3'(arb_idx)));
                        oerr_q     <= len_bad;
                        len_bad_q  <= len_bad;
                        oport_q    <= arb_idx;
                        olen_q     <= head_len;
                        state_q    <= ST_POP;
                    end
                end
                ST_POP: begin
                    last_q <= grant_q;
                    if (len_bad_q) begin
                        state_q <= ST_GAP;
                    end else begin
                        rd_cnt_q <= olen_q;
                        first_q  <= 1'b1;
                        ord_en_q <= grant_oh_q;
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    first_q  <= 1'b0;
                    rd_cnt_q <= rd_cnt_q - pLEN_WIDTH'(1);
                    if (rd_cnt_q == pLEN_WIDTH'(1)) begin
                        ord_en_q <= '0;
                        // Reused as the drain countdown: L-1 DRAIN cycles.
                        rd_cnt_q <= pLEN_WIDTH'(L - 2);
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_cnt_q == '0) state_q <= ST_GAP;
                    else rd_cnt_q <= rd_cnt_q - pLEN_WIDTH'(1);
                end
                ST_GAP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ord_en     = ord_en_q;
    assign olen_pop   = olen_pop_q;
    assign odata      = odata_q;
    assign odv        = vld_q[L-1];
    assign osop       = sop_q[L-1];
    assign oeop       = eop_q[L-1];
    assign oport      = oport_q;
    assign olen       = olen_q;
    assign oerr       = oerr_q;
    assign odbg_state = state_q;

endmodule

// File: tb/tb_packet_buffer_read_scheduler.sv
module tb_packet_buffer_read_scheduler;
  import copy_mem_pkg::*;

  localparam int P  = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  // ---------------- clock / reset ----------------
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic            i_rst;
  logic [P-1:0]    iempty;
  logic [P*LW-1:0] ilen;
  logic [P*DW-1:0] ird_data = '0;
  logic            idst_ready;
  logic [P-1:0]    ord_en;
  logic [P-1:0]    olen_pop;
  logic [DW-1:0]   odata;
  logic            odv, osop, oeop, oerr;
  logic [1:0]      oport;
  logic [LW-1:0]   olen;
  state_e          dbg_state;

  packet_buffer_read_scheduler #(
    .pPORTS(P), .pDATA_WIDTH(DW), .pLEN_WIDTH(LW),
    .pMAX_PACKET_LENGHT(1536), .pRD_LATENCY(1)
  ) dut (
    .iclk(iclk), .i_rst(i_rst), .iempty(iempty), .ilen(ilen),
    .ird_data(ird_data), .idst_ready(idst_ready), .ord_en(ord_en),
    .olen_pop(olen_pop), .odata(odata), .odv(odv), .osop(osop),
    .oeop(oeop), .oport(oport), .olen(olen), .oerr(oerr),
    .odbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  // ---------------- buffer models ----------------
  // Length FIFO per port: written by stimulus, popped on olen_pop.
  logic [LW-1:0] plen [P][8];
  int ph [P];
  int pt [P];

  always_comb begin
    iempty = '1;
    ilen   = '0;
    for (int i = 0; i < P; i++) begin
      iempty[i] = (ph[i] == pt[i]);
      ilen[i*LW +: LW] = plen[i][3'(ph[i])];
    end
  end

  always @(posedge iclk) begin
    for (int i = 0; i < P; i++)
      if (olen_pop[i] && ph[i] != pt[i]) ph[i] <= ph[i] + 1;
  end

  // Packet SRAM: byte k of a packet from port p reads as 8'(p*40 + k), 1-cycle latency.
  int ptr [P];
  always @(posedge iclk) begin
    for (int i = 0; i < P; i++) begin
      if (olen_pop[i]) ptr[i] <= 0;
      else if (ord_en[i]) begin
        ird_data[i*DW +: DW] <= 8'(i*40 + ptr[i]);
        ptr[i] <= ptr[i] + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_pops = 0, err_cnt = 0, odv_cnt = 0, data_bad = 0;
  int sop_cnt = 0, eop_cnt = 0, n_pkts = 0, sop_cyc = 0, eop_cyc = 0;
  int pop_order [64];
  int pop_cyc [64];
  int pop_err [64];
  int en_cnt [P];
  logic [31:0] pkt_desc [64];
  logic [LW-1:0] pkt_olen [64];
  logic in_pkt = 1'b0;
  logic [7:0] prev_b, first_b;
  logic [15:0] bcnt;

  always @(negedge iclk) begin
    if (i_rst) begin
      in_pkt = 1'b0;
    end else begin
      for (int i = 0; i < P; i++) begin
        if (olen_pop[i]) begin
          if (n_pops < 64) begin
            pop_order[n_pops] = i;
            pop_cyc[n_pops]   = cyc;
            pop_err[n_pops]   = int'(oerr);
          end
          n_pops++;
        end
        if (ord_en[i]) en_cnt[i]++;
      end
      if (oerr) err_cnt++;
      if (odv) begin
        odv_cnt++;
        if (osop) begin
          sop_cnt++;
          sop_cyc = cyc;
          if (in_pkt) data_bad++;
          in_pkt  = 1'b1;
          bcnt    = 16'd0;
          first_b = odata;
        end else if (!in_pkt || odata != 8'(prev_b + 8'd1)) begin
          data_bad++;
        end
        prev_b = odata;
        bcnt   = bcnt + 16'd1;
        if (oeop) begin
          eop_cnt++;
          eop_cyc = cyc;
          in_pkt  = 1'b0;
          if (n_pkts < 64) begin
            pkt_desc[n_pkts] = {first_b, 8'(oport), bcnt};
            pkt_olen[n_pkts] = olen;
          end
          n_pkts++;
        end
      end else if (in_pkt) begin
        data_bad++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int b_pop, b_pkt, b_odv, b_err, b_bad, b_sop, b_eop;
  int b_en [P];

  task automatic snap();
    b_pop = n_pops; b_pkt = n_pkts; b_odv = odv_cnt; b_err = err_cnt;
    b_bad = data_bad; b_sop = sop_cnt; b_eop = eop_cnt;
    for (int i = 0; i < P; i++) b_en[i] = en_cnt[i];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic push_pkt(input int p, input int len);
    plen[p][3'(pt[p])] = 16'(len);
    pt[p] = pt[p] + 1;
  endtask

  task automatic expect_pkt(input int p, input int len);
    exp_q.push_back({8'(p*40), 8'(p), 16'(len)});
  endtask

  task automatic wait_pkts(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_pkts >= target) break;
      tick(1);
    end
    check("wait_pkts", n_pkts, target);
    tick(3);
  endtask

  task automatic check_pkts(input string tag);
    int idx;
    logic [31:0] e;
    idx = b_pkt;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (idx < 64) begin
        check({tag, "_desc"}, pkt_desc[idx], e);
        check({tag, "_olen"}, pkt_olen[idx], e[15:0]);
      end
      idx++;
    end
    check({tag, "_count"}, n_pkts - b_pkt, idx - b_pkt);
    check({tag, "_data"}, data_bad - b_bad, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_en_pop"}, {ord_en, olen_pop}, 0);
    check({tag, "_flags"}, {odv, osop, oeop, oerr}, 0);
    check({tag, "_odata"}, odata, 0);
    check({tag, "_port_len"}, {oport, olen}, 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idst_ready = 1'b0;
    tick(2);
    check_quiet("rst");
    i_rst = 1'b0;
  endtask

  int ord [6] = '{0, 1, 3, 0, 1, 3};
  int raise_cyc;

  // ---------------- stimulus ----------------
  initial begin
    i_rst = 1'b1;
    idst_ready = 1'b0;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < 8; j++) plen[i][j] = '0;
    do_reset();
    tick(1);

    // Single packet, port 2, length 64.
    snap();
    push_pkt(2, 64); expect_pkt(2, 64);
    idst_ready = 1'b1;
    wait_pkts(b_pkt + 1, 200);
    check("t1_pops", n_pops - b_pop, 1);
    check("t1_pop_port", pop_order[b_pop], 2);
    check("t1_en2", en_cnt[2] - b_en[2], 64);
    check("t1_en_other", (en_cnt[0] - b_en[0]) + (en_cnt[1] - b_en[1]) + (en_cnt[3] - b_en[3]), 0);
    check("t1_odv", odv_cnt - b_odv, 64);
    check("t1_sop_lat", sop_cyc - pop_cyc[b_pop], 3);
    check("t1_span", eop_cyc - sop_cyc, 63);
    check_pkts("t1_pkt");

    // Round-robin among ports 0,1,3.
    do_reset();
    snap();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 10); push_pkt(1, 10); push_pkt(3, 10);
      expect_pkt(0, 10); expect_pkt(1, 10); expect_pkt(3, 10);
    end
    idst_ready = 1'b1;
    wait_pkts(b_pkt + 6, 400);
    for (int j = 0; j < 6; j++) check("t2_order", pop_order[b_pop + j], ord[j]);
    check("t2_spacing", pop_cyc[b_pop + 1] - pop_cyc[b_pop], 14);
    check_pkts("t2_pkt");

    // Length 1 on port 1.
    snap();
    push_pkt(1, 1); expect_pkt(1, 1);
    wait_pkts(b_pkt + 1, 50);
    check("t3_odv", odv_cnt - b_odv, 1);
    check("t3_sop_eop", {sop_cnt - b_sop, eop_cnt - b_eop}, {32'd1, 32'd1});
    check("t3_same_byte", eop_cyc - sop_cyc, 0);
    check_pkts("t3_pkt");

    // Illegal lengths 0 and 1537, then 60 and the 1536 maximum.
    snap();
    push_pkt(0, 0); push_pkt(0, 1537); push_pkt(0, 60); push_pkt(0, 1536);
    expect_pkt(0, 60); expect_pkt(0, 1536);
    wait_pkts(b_pkt + 2, 2000);
    check("t4_err", err_cnt - b_err, 2);
    check("t4_pops", n_pops - b_pop, 4);
    check("t4_pop_err", {pop_err[b_pop][0], pop_err[b_pop+1][0], pop_err[b_pop+2][0], pop_err[b_pop+3][0]}, 4'b1100);
    check("t4_err_gap0", pop_cyc[b_pop + 1] - pop_cyc[b_pop], 3);
    check("t4_err_gap1", pop_cyc[b_pop + 2] - pop_cyc[b_pop + 1], 3);
    check("t4_en0", en_cnt[0] - b_en[0], 1596);
    check("t4_odv", odv_cnt - b_odv, 1596);
    check_pkts("t4_pkt");

    // Downstream not ready, then ready, then dropped mid-packet.
    idst_ready = 1'b0;
    snap();
    push_pkt(0, 30); expect_pkt(0, 30);
    tick(20);
    check("t5_held", n_pops - b_pop, 0);
    idst_ready = 1'b1;
    raise_cyc = cyc;
    tick(10);
    idst_ready = 1'b0;
    check("t5_pop_lat", pop_cyc[b_pop] - raise_cyc, 1);
    wait_pkts(b_pkt + 1, 100);
    check("t5_odv", odv_cnt - b_odv, 30);
    check_pkts("t5_pkt");

    // Reset in the middle of a 100-byte packet.
    snap();
    idst_ready = 1'b1;
    push_pkt(2, 100);
    for (int i = 0; i < 200; i++) begin
      if (odv_cnt - b_odv >= 30) break;
      tick(1);
    end
    check("t6_reach30", odv_cnt - b_odv, 30);
    i_rst = 1'b1;
    push_pkt(3, 20); push_pkt(0, 20);
    expect_pkt(0, 20); expect_pkt(3, 20);
    tick(1);
    check_quiet("t6_rst");
    check("t6_no_eop", eop_cnt - b_eop, 0);
    tick(1);
    i_rst = 1'b0;
    wait_pkts(b_pkt + 2, 300);
    check("t6_first", pop_order[b_pop + 1], 0);
    check("t6_second", pop_order[b_pop + 2], 3);
    check_pkts("t6_pkt");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
